// File: rtl/yacc_result_logger.sv
// Result-side logger for the YACC compressed cache: buffers per-access outcome
// records in a first-word fall-through FIFO and keeps saturating hit/miss statistics.
module yacc_result_logger #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned ENTRY_W      = 8,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEPTH        = 16,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic [ADDR_W-1:0]        acc_addr,
  input  logic                     acc_hit,
  input  logic [ENTRY_W-1:0]       acc_entry,
  input  logic                     clear,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_seq,
  output logic [ADDR_W-1:0]        rec_addr,
  output logic                     rec_hit,
  output logic [ENTRY_W-1:0]       rec_entry,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned REC_W = CNT_W + ADDR_W + 1 + ENTRY_W;

  logic [REC_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_seq;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_hit;
  logic [CNT_W-1:0]   r_miss;
  logic [CNT_W-1:0]   r_drop;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [CNT_W-1:0]   w_seq_base;
  logic [CNT_W-1:0]   w_seq_nxt;
  logic [CNT_W-1:0]   w_total_nxt;
  logic [CNT_W-1:0]   w_hit_nxt;
  logic [CNT_W-1:0]   w_miss_nxt;
  logic [CNT_W-1:0]   w_drop_nxt;
  logic [REC_W-1:0]   w_head;
  logic [CNT_W-1:0]   w_h_seq;
  logic [ADDR_W-1:0]  w_h_addr;
  logic               w_h_hit;
  logic [ENTRY_W-1:0] w_h_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Full/empty come from registered pointers only, so acc_ready never sees acc_valid.
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign acc_ready = DROP_ON_FULL ? 1'b1 : !w_full;
  assign w_accept  = acc_valid && acc_ready;
  assign w_push    = w_accept && !w_full;
  assign w_drop    = w_accept && w_full;
  assign w_pop     = !w_empty && rec_ready;

  // Clear applies first so a same-cycle accept lands on zeroed counters.
  always_comb begin
    w_seq_base  = clear ? '0 : r_seq;
    w_seq_nxt   = w_seq_base;
    w_total_nxt = clear ? '0 : r_total;
    w_hit_nxt   = clear ? '0 : r_hit;
    w_miss_nxt  = clear ? '0 : r_miss;
    w_drop_nxt  = clear ? '0 : r_drop;
    if (w_accept) begin
      w_seq_nxt   = w_seq_base + CNT_W'(1);
      w_total_nxt = sat_inc(w_total_nxt);
      if (acc_hit) w_hit_nxt  = sat_inc(w_hit_nxt);
      else         w_miss_nxt = sat_inc(w_miss_nxt);
      if (w_drop)  w_drop_nxt = sat_inc(w_drop_nxt);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_seq    <= '0;
      r_total  <= '0;
      r_hit    <= '0;
      r_miss   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_seq   <= w_seq_nxt;
      r_total <= w_total_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Record storage needs no reset; unread slots are masked by the empty flag.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_seq_base, acc_addr, acc_hit, acc_entry};
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign {w_h_seq, w_h_addr, w_h_hit, w_h_entry} = w_head;

  assign rec_valid = !w_empty;
  assign rec_seq   = w_empty ? '0 : w_h_seq;
  assign rec_addr  = w_empty ? '0 : w_h_addr;
  assign rec_hit   = w_empty ? 1'b0 : w_h_hit;
  assign rec_entry = w_empty ? '0 : w_h_entry;
  assign fill      = r_wr_ptr - r_rd_ptr;
  assign total_cnt = r_total;
  assign hit_cnt   = r_hit;
  assign miss_cnt  = r_miss;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_yacc_result_logger.sv
// Directed bench for yacc_result_logger: backpressure, drop-on-full and
// narrow-counter instances checked against hand-computed values.
module tb_yacc_result_logger;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // Instance A: backpressure, 32-bit counters
  logic        a_valid = 0, a_ready, a_hit = 0, a_clear = 0, a_rrdy = 0;
  logic [31:0] a_addr = '0;
  logic [7:0]  a_entry = '0;
  logic        a_rvalid, a_rhit;
  logic [31:0] a_seq, a_raddr, a_total, a_hitc, a_miss, a_drop;
  logic [7:0]  a_rentry;
  logic [4:0]  a_fill;

  yacc_result_logger #(.DROP_ON_FULL(1'b0)) dut_a (
    .clock(clk), .reset_n(rst_n), .acc_valid(a_valid), .acc_ready(a_ready),
    .acc_addr(a_addr), .acc_hit(a_hit), .acc_entry(a_entry), .clear(a_clear),
    .rec_valid(a_rvalid), .rec_ready(a_rrdy), .rec_seq(a_seq), .rec_addr(a_raddr),
    .rec_hit(a_rhit), .rec_entry(a_rentry), .fill(a_fill), .total_cnt(a_total),
    .hit_cnt(a_hitc), .miss_cnt(a_miss), .drop_cnt(a_drop));

  // Instance B: drop on full
  logic        b_valid = 0, b_ready, b_hit = 0, b_clear = 0, b_rrdy = 0;
  logic [31:0] b_addr = '0;
  logic [7:0]  b_entry = '0;
  logic        b_rvalid, b_rhit;
  logic [31:0] b_seq, b_raddr, b_total, b_hitc, b_miss, b_drop;
  logic [7:0]  b_rentry;
  logic [4:0]  b_fill;

  yacc_result_logger #(.DROP_ON_FULL(1'b1)) dut_b (
    .clock(clk), .reset_n(rst_n), .acc_valid(b_valid), .acc_ready(b_ready),
    .acc_addr(b_addr), .acc_hit(b_hit), .acc_entry(b_entry), .clear(b_clear),
    .rec_valid(b_rvalid), .rec_ready(b_rrdy), .rec_seq(b_seq), .rec_addr(b_raddr),
    .rec_hit(b_rhit), .rec_entry(b_rentry), .fill(b_fill), .total_cnt(b_total),
    .hit_cnt(b_hitc), .miss_cnt(b_miss), .drop_cnt(b_drop));

  // Instance C: 4-bit counters for saturation and seq wrap
  logic        c_valid = 0, c_ready, c_hit = 0, c_clear = 0, c_rrdy = 0;
  logic [31:0] c_addr = '0;
  logic [7:0]  c_entry = '0;
  logic        c_rvalid, c_rhit;
  logic [3:0]  c_seq, c_total, c_hitc, c_miss, c_drop;
  logic [31:0] c_raddr;
  logic [7:0]  c_rentry;
  logic [4:0]  c_fill;

  yacc_result_logger #(.CNT_W(4), .DROP_ON_FULL(1'b0)) dut_c (
    .clock(clk), .reset_n(rst_n), .acc_valid(c_valid), .acc_ready(c_ready),
    .acc_addr(c_addr), .acc_hit(c_hit), .acc_entry(c_entry), .clear(c_clear),
    .rec_valid(c_rvalid), .rec_ready(c_rrdy), .rec_seq(c_seq), .rec_addr(c_raddr),
    .rec_hit(c_rhit), .rec_entry(c_rentry), .fill(c_fill), .total_cnt(c_total),
    .hit_cnt(c_hitc), .miss_cnt(c_miss), .drop_cnt(c_drop));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tot++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", a_rvalid); end
    tot++; if (a_fill !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", a_fill); end
    tot++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", a_ready); end
    tot++; if (a_total !== 32'd0 || a_drop !== 32'd0) begin bad++; $display("FAIL reset_cnt total=%0d drop=%0d exp=0", a_total, a_drop); end
    tot++; if (a_seq !== 32'd0 || a_raddr !== 32'd0 || a_rentry !== 8'd0) begin bad++; $display("FAIL reset_rec seq=%0h addr=%0h entry=%0h exp=0", a_seq, a_raddr, a_rentry); end
  endtask

  task automatic test_basic;
    logic [31:0] addrs [3];
    logic        hits  [3];
    addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h3000;
    hits[0] = 1'b1; hits[1] = 1'b0; hits[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_addr = addrs[i]; a_hit = hits[i]; a_entry = 8'(i + 5);
      tick();
      if (i == 0) begin
        tot++; if (a_rvalid !== 1'b1 || a_seq !== 32'd0) begin bad++; $display("FAIL basic_push_latency rvalid=%0b seq=%0d exp 1/0", a_rvalid, a_seq); end
      end
    end
    a_valid = 0;
    tot++; if (a_fill !== 5'd3) begin bad++; $display("FAIL basic_fill got=%0d exp=3", a_fill); end
    tot++; if (a_total !== 32'd3 || a_hitc !== 32'd2 || a_miss !== 32'd1) begin bad++; $display("FAIL basic_cnt total=%0d hit=%0d miss=%0d exp 3/2/1", a_total, a_hitc, a_miss); end
    for (int i = 0; i < 3; i++) begin
      tot++;
      if (a_rvalid !== 1'b1 || a_seq !== 32'(i) || a_raddr !== addrs[i] || a_rhit !== hits[i] || a_rentry !== 8'(i + 5)) begin
        bad++; $display("FAIL basic_drain%0d seq=%0d addr=%0h hit=%0b entry=%0d exp seq=%0d addr=%0h", i, a_seq, a_raddr, a_rhit, a_rentry, i, addrs[i]);
      end
      a_rrdy = 1; tick(); a_rrdy = 0;
    end
    tot++; if (a_rvalid !== 1'b0 || a_fill !== 5'd0) begin bad++; $display("FAIL basic_empty rvalid=%0b fill=%0d exp 0/0", a_rvalid, a_fill); end
  endtask

  task automatic test_backpressure;
    a_clear = 1; tick(); a_clear = 0;
    tot++; if (a_total !== 32'd0 || a_hitc !== 32'd0) begin bad++; $display("FAIL bp_clear total=%0d hit=%0d exp 0", a_total, a_hitc); end
    for (int i = 0; i < 20; i++) begin
      a_valid = 1; a_addr = 32'(i); a_hit = 1'b0;
      if (i == 15) begin
        tot++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ready15 got=%0b exp=1", a_ready); end
      end
      if (i == 16) begin
        tot++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_ready16 got=%0b exp=0", a_ready); end
      end
      tick();
    end
    a_valid = 0;
    tot++; if (a_fill !== 5'd16 || a_total !== 32'd16) begin bad++; $display("FAIL bp_full fill=%0d total=%0d exp 16/16", a_fill, a_total); end
    // pop while full with a pending source: no push, ready returns next cycle
    a_valid = 1; a_rrdy = 1; tick(); a_valid = 0; a_rrdy = 0;
    tot++; if (a_ready !== 1'b1 || a_fill !== 5'd15 || a_total !== 32'd16) begin bad++; $display("FAIL bp_pop ready=%0b fill=%0d total=%0d exp 1/15/16", a_ready, a_fill, a_total); end
    tot++; if (a_seq !== 32'd1) begin bad++; $display("FAIL bp_head got=%0d exp=1", a_seq); end
    a_rrdy = 1; repeat (15) tick(); a_rrdy = 0;
    tot++; if (a_fill !== 5'd0) begin bad++; $display("FAIL bp_drain fill=%0d exp=0", a_fill); end
  endtask

  task automatic test_stream;
    int errs;
    errs = 0;
    a_clear = 1; tick(); a_clear = 0;
    a_rrdy = 1;
    for (int i = 0; i < 100; i++) begin
      a_valid = 1; a_addr = 32'(i * 4); a_hit = 1'b1;
      tick();
      tot++;
      if (a_fill !== 5'd1 || a_seq !== 32'(i) || a_raddr !== 32'(i * 4)) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL stream%0d fill=%0d seq=%0d addr=%0h exp fill=1 seq=%0d", i, a_fill, a_seq, a_raddr, i);
      end
    end
    a_valid = 0; tick(); a_rrdy = 0;
    tot++; if (a_fill !== 5'd0 || a_total !== 32'd100) begin bad++; $display("FAIL stream_end fill=%0d total=%0d exp 0/100", a_fill, a_total); end
  endtask

  task automatic test_clear_accept;
    a_clear = 1; tick(); a_clear = 0;
    for (int i = 0; i < 50; i++) begin
      a_valid = 1; a_addr = 32'(i); a_hit = i[0]; a_rrdy = (i < 47);
      tick();
    end
    a_valid = 0; a_rrdy = 0;
    tot++; if (a_fill !== 5'd4 || a_total !== 32'd50 || a_seq !== 32'd46) begin bad++; $display("FAIL clr_pre fill=%0d total=%0d head=%0d exp 4/50/46", a_fill, a_total, a_seq); end
    a_valid = 1; a_clear = 1; a_addr = 32'hABCD; a_hit = 1'b0; a_entry = 8'h3C;
    tick();
    a_valid = 0; a_clear = 0;
    tot++; if (a_total !== 32'd1 || a_miss !== 32'd1 || a_hitc !== 32'd0 || a_drop !== 32'd0) begin bad++; $display("FAIL clr_cnt total=%0d miss=%0d hit=%0d drop=%0d exp 1/1/0/0", a_total, a_miss, a_hitc, a_drop); end
    tot++; if (a_fill !== 5'd5) begin bad++; $display("FAIL clr_fill got=%0d exp=5", a_fill); end
    for (int i = 0; i < 4; i++) begin
      tot++; if (a_seq !== 32'(46 + i)) begin bad++; $display("FAIL clr_old%0d seq=%0d exp=%0d", i, a_seq, 46 + i); end
      a_rrdy = 1; tick(); a_rrdy = 0;
    end
    tot++; if (a_seq !== 32'd0 || a_raddr !== 32'hABCD || a_rhit !== 1'b0 || a_rentry !== 8'h3C) begin bad++; $display("FAIL clr_rec seq=%0d addr=%0h hit=%0b entry=%0h exp 0/abcd/0/3c", a_seq, a_raddr, a_rhit, a_rentry); end
    a_rrdy = 1; tick(); a_rrdy = 0;
  endtask

  task automatic test_drop;
    int errs;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1; b_addr = 32'(i + 100); b_hit = 1'b1;
      if (i == 19) begin
        tot++; if (b_ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%0b exp=1", b_ready); end
      end
      tick();
    end
    b_valid = 0;
    tot++; if (b_fill !== 5'd16 || b_total !== 32'd20 || b_drop !== 32'd4 || b_hitc !== 32'd20) begin bad++; $display("FAIL drop_cnt fill=%0d total=%0d drop=%0d hit=%0d exp 16/20/4/20", b_fill, b_total, b_drop, b_hitc); end
    // push and pop together while full: push dropped (seq 20 consumed), pop proceeds
    b_valid = 1; b_rrdy = 1; tick(); b_valid = 0; b_rrdy = 0;
    tot++; if (b_fill !== 5'd15 || b_drop !== 32'd5 || b_total !== 32'd21) begin bad++; $display("FAIL drop_fullpp fill=%0d drop=%0d total=%0d exp 15/5/21", b_fill, b_drop, b_total); end
    for (int i = 1; i < 16; i++) begin
      tot++;
      if (b_seq !== 32'(i) || b_raddr !== 32'(i + 100)) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL drop_drain%0d seq=%0d addr=%0d exp %0d/%0d", i, b_seq, b_raddr, i, i + 100);
      end
      b_rrdy = 1; tick(); b_rrdy = 0;
    end
    b_valid = 1; tick(); b_valid = 0;
    tot++; if (b_seq !== 32'd21 || b_fill !== 5'd1) begin bad++; $display("FAIL drop_next seq=%0d fill=%0d exp 21/1", b_seq, b_fill); end
  endtask

  task automatic test_saturate;
    int errs;
    errs = 0;
    c_rrdy = 1;
    for (int i = 0; i < 20; i++) begin
      c_valid = 1; c_hit = 1'b1; c_addr = 32'(i);
      tick();
      tot++;
      if (c_seq !== 4'(i) || c_fill !== 5'd1) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL sat_seq%0d seq=%0d fill=%0d exp %0d/1", i, c_seq, c_fill, i % 16);
      end
    end
    c_valid = 0; tick(); c_rrdy = 0;
    tot++; if (c_total !== 4'hF || c_hitc !== 4'hF || c_miss !== 4'h0) begin bad++; $display("FAIL sat_cnt total=%0d hit=%0d miss=%0d exp 15/15/0", c_total, c_hitc, c_miss); end
  endtask

  task automatic test_reset_midstream;
    a_valid = 1; a_addr = 32'h55; tick(); tick(); a_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    tot++; if (a_rvalid !== 1'b0 || a_fill !== 5'd0 || a_total !== 32'd0) begin bad++; $display("FAIL midrst rvalid=%0b fill=%0d total=%0d exp 0/0/0", a_rvalid, a_fill, a_total); end
    tick(); rst_n = 1'b1; tick();
    a_valid = 1; a_addr = 32'h77; tick(); a_valid = 0;
    tot++; if (a_seq !== 32'd0 || a_raddr !== 32'h77 || a_fill !== 5'd1) begin bad++; $display("FAIL midrst_seq seq=%0d addr=%0h fill=%0d exp 0/77/1", a_seq, a_raddr, a_fill); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_clear_accept();
    test_drop();
    test_saturate();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
